// File: rtl/tc_pkg.sv
// Shared constants for the sparse tensor core partial-sum path: default tile
// geometry, controller state encodings and the buffer arm latency.
package tc_pkg;

    localparam int TC_M         = 16;
    localparam int TC_N         = 16;
    localparam int TC_TILE_M    = 4;
    localparam int TC_DW_DATA   = 8;
    localparam int TC_DW_POS    = 4;
    localparam int TC_DW_K      = 8;
    localparam int TC_DRAIN_CYC = 20;

    // Cycles spent in ARM before beats are accepted (buffer input-phase entry latency)
    localparam int ARM_CYC = 3;

    typedef logic [2:0] tc_state_t;

    localparam tc_state_t ST_IDLE  = 3'd0;
    localparam tc_state_t ST_CLEAR = 3'd1;
    localparam tc_state_t ST_ARM   = 3'd2;
    localparam tc_state_t ST_ACCUM = 3'd3;
    localparam tc_state_t ST_DRAIN = 3'd4;
    localparam tc_state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/tc_tile_walker.sv
// Walks an M x N output tile in TILE_M-row beats, column-fastest, k_steps times.
// Shared with the weight-fetch sequencer, so it knows nothing about the buffer.
module tc_tile_walker #(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int TILE_M = 4,
    parameter int DW_POS = 4,
    parameter int DW_K   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [DW_K-1:0]   k_steps,
    output logic [DW_POS-1:0] row,
    output logic [DW_POS-1:0] col,
    output logic              last
);

    localparam logic [DW_POS-1:0] COL_LAST = DW_POS'(N - 1);
    localparam logic [DW_POS-1:0] ROW_LAST = DW_POS'(M - TILE_M);
    localparam logic [DW_POS-1:0] ROW_STEP = DW_POS'(TILE_M);

    logic [DW_K-1:0] kcnt;
    logic            col_wrap;
    logic            row_wrap;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);

    // The current address is the one the next beat lands on; last flags the final beat of the job
    assign last = col_wrap && row_wrap && ((kcnt + DW_K'(1)) == k_steps);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row  <= '0;
            col  <= '0;
            kcnt <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row  <= '0;
                    kcnt <= kcnt + DW_K'(1);
                end else begin
                    row <= row + ROW_STEP;
                end
            end else begin
                col <= col + DW_POS'(1);
            end
        end
    end

endmodule

// File: rtl/tc_psum_ctrl.sv
// Job sequencer for the partial-sum accumulation buffer: clears and arms the buffer,
// streams k_steps passes of upstream beats into it, then runs the drain window.
module tc_psum_ctrl
    import tc_pkg::*;
#(
    parameter int M         = TC_M,
    parameter int N         = TC_N,
    parameter int TILE_M    = TC_TILE_M,
    parameter int DW_DATA   = TC_DW_DATA,
    parameter int DW_POS    = TC_DW_POS,
    parameter int DW_K      = TC_DW_K,
    parameter int DRAIN_CYC = TC_DRAIN_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DW_K-1:0]           k_steps,
    output logic                      busy,
    output logic                      done,
    input  logic                      up_valid,
    output logic                      up_ready,
    input  logic [TILE_M*DW_DATA-1:0] up_data,
    output logic                      ps_clr,
    output logic                      ps_input_en,
    output logic                      ps_out_en,
    output logic [DW_POS-1:0]         ps_row,
    output logic [DW_POS-1:0]         ps_col,
    output logic [TILE_M*DW_DATA-1:0] ps_in,
    input  logic                      ps_out_valid,
    output logic                      dn_row_valid,
    output logic [DW_POS-1:0]         dn_row_idx
);

    localparam int DCW = $clog2(DRAIN_CYC);

    tc_state_t         state;
    logic [DW_K-1:0]   k_lat;
    logic [1:0]        arm_cnt;
    logic [DCW-1:0]    drain_cnt;
    logic [DW_POS:0]   rows_seen;
    logic [DW_POS-1:0] walk_row;
    logic [DW_POS-1:0] walk_col;
    logic              walk_last;
    logic              xfer;

    tc_tile_walker #(
        .M      (M),
        .N      (N),
        .TILE_M (TILE_M),
        .DW_POS (DW_POS),
        .DW_K   (DW_K)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_CLEAR),
        .advance (xfer),
        .k_steps (k_lat),
        .row     (walk_row),
        .col     (walk_col),
        .last    (walk_last)
    );

    assign up_ready    = (state == ST_ACCUM);
    assign xfer        = up_valid && up_ready;
    assign busy        = (state == ST_CLEAR) || (state == ST_ARM) ||
                         (state == ST_ACCUM) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign ps_clr      = (state == ST_CLEAR);
    assign ps_input_en = (state == ST_ARM) && (arm_cnt == 2'd0);
    // DRAIN opens while the last beat is still on ps_*, so the drain strobe waits one cycle
    assign ps_out_en   = (state == ST_DRAIN) && (drain_cnt == DCW'(1));

    // Rows past M are spurious buffer output and never reach downstream
    assign dn_row_valid = (state == ST_DRAIN) && ps_out_valid &&
                          (rows_seen < (DW_POS+1)'(M));
    assign dn_row_idx   = rows_seen[DW_POS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_lat     <= '0;
            arm_cnt   <= '0;
            drain_cnt <= '0;
            rows_seen <= '0;
            ps_in     <= '0;
            ps_row    <= '0;
            ps_col    <= '0;
        end else begin
            // The buffer sums every input-phase cycle, so idle cycles must present zero
            ps_in <= xfer ? up_data : '0;
            if (xfer) begin
                ps_row <= walk_row;
                ps_col <= walk_col;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_lat <= k_steps;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    arm_cnt   <= '0;
                    drain_cnt <= '0;
                    rows_seen <= '0;
                    state     <= (k_lat == '0) ? ST_DRAIN : ST_ARM;
                end
                ST_ARM: begin
                    if (arm_cnt == 2'(ARM_CYC - 1)) begin
                        state <= ST_ACCUM;
                    end else begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end
                end
                ST_ACCUM: begin
                    if (xfer && walk_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + DCW'(1);
                    if (dn_row_valid) begin
                        rows_seen <= rows_seen + (DW_POS+1)'(1);
                    end
                    if (drain_cnt == DCW'(DRAIN_CYC - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rows_seen <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_psum_ctrl.sv
// Randomized bench for tc_psum_ctrl: a schedule-level reference model plus a
// behavioural accumulation buffer that sums whatever the controller presents.
module tb_tc_psum_ctrl;
    import tc_pkg::*;

    localparam int M         = TC_M;
    localparam int N         = TC_N;
    localparam int TILE_M    = TC_TILE_M;
    localparam int DW_DATA   = TC_DW_DATA;
    localparam int DW_POS    = TC_DW_POS;
    localparam int DW_K      = TC_DW_K;
    localparam int DRAIN_CYC = TC_DRAIN_CYC;
    localparam int BPP       = N * M / TILE_M;
    localparam int DW_BEAT   = TILE_M * DW_DATA;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [DW_K-1:0]     k_steps = '0;
    logic                busy, done;
    logic                up_valid = 1'b0;
    logic                up_ready;
    logic [DW_BEAT-1:0]  up_data = '0;
    logic                ps_clr, ps_input_en, ps_out_en;
    logic [DW_POS-1:0]   ps_row, ps_col;
    logic [DW_BEAT-1:0]  ps_in;
    logic                ps_out_valid = 1'b0;
    logic                dn_row_valid;
    logic [DW_POS-1:0]   dn_row_idx;

    int n_cmp  = 0;
    int n_fail = 0;
    int buf_acc [M][N];
    int exp_acc [M][N];
    bit armed  = 1'b0;
    int m_row  = 0;
    int m_col  = 0;

    always #5 clk = ~clk;

    tc_psum_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_steps      (k_steps),
        .busy         (busy),
        .done         (done),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .ps_clr       (ps_clr),
        .ps_input_en  (ps_input_en),
        .ps_out_en    (ps_out_en),
        .ps_row       (ps_row),
        .ps_col       (ps_col),
        .ps_in        (ps_in),
        .ps_out_valid (ps_out_valid),
        .dn_row_valid (dn_row_valid),
        .dn_row_idx   (dn_row_idx)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural buffer: cleared by ps_clr, sums ps_in between arm and drain strobes
    task automatic bufferSample();
        if (ps_clr) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    buf_acc[r][c] = 0;
        end
        if (ps_input_en) armed = 1'b1;
        if (armed) begin
            for (int l = 0; l < TILE_M; l++)
                if (int'(ps_row) + l < M)
                    buf_acc[int'(ps_row) + l][ps_col] += int'(ps_in[l*DW_DATA +: DW_DATA]);
        end
        if (ps_out_en) armed = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_up_ready"}, up_ready, 0);
        checkOutput({tag, "_ps_clr"}, ps_clr, 0);
        checkOutput({tag, "_ps_input_en"}, ps_input_en, 0);
        checkOutput({tag, "_ps_out_en"}, ps_out_en, 0);
        checkOutput({tag, "_ps_row"}, ps_row, 0);
        checkOutput({tag, "_ps_col"}, ps_col, 0);
        checkOutput({tag, "_ps_in"}, ps_in, 0);
        checkOutput({tag, "_dn_row_valid"}, dn_row_valid, 0);
        checkOutput({tag, "_dn_row_idx"}, dn_row_idx, 0);
    endtask

    // vmode: 0 valid held, 1 valid toggling, 2 random; dmode: 0 all-ones lanes, 1 random
    task automatic applyStimulus(input int k, input int vmode, input int dmode,
                                 input int out_rows, input int rst_at, input bit poke);
        int t, sent, total, d, pe_cyc, rows, t_done, limit, b, r, c;
        bit v, exp_ready, pend, exp_dn;
        logic [DW_BEAT-1:0] data, pend_data, ones;
        int pend_row, pend_col;

        t = 0; sent = 0; total = k * BPP; pe_cyc = -1; rows = 0; t_done = -1;
        d = (k == 0) ? 2 : (1 << 30);
        limit = 60 + total * 8 + DRAIN_CYC;
        pend = 1'b0; pend_data = '0; pend_row = 0; pend_col = 0;
        ones = {TILE_M{DW_DATA'(1)}};
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                exp_acc[i][j] = 0;

        @(negedge clk);
        start = 1'b1; k_steps = DW_K'(k); up_valid = 1'b0; ps_out_valid = 1'b0;

        // t counts cycles from the first busy cycle (CLEAR is t=1)
        while (1) begin
            @(negedge clk);
            t++;
            start    = poke && ((k > 0 && t == 12) || t == d + DRAIN_CYC);
            k_steps  = DW_K'($urandom);
            v        = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 2 == 0) : ($urandom_range(3, 0) != 0);
            data     = (dmode == 0) ? ones : DW_BEAT'($urandom);
            up_valid = v;
            up_data  = data;
            ps_out_valid = (pe_cyc >= 0) && (t > pe_cyc) && (t <= pe_cyc + out_rows);
            #1;

            exp_ready = (k > 0) && (t >= ARM_CYC + 2) && (sent < total);
            if (pend) begin
                m_row = pend_row;
                m_col = pend_col;
            end
            checkOutput("busy", busy, (t < d + DRAIN_CYC));
            checkOutput("done", done, (t == d + DRAIN_CYC));
            checkOutput("ps_clr", ps_clr, (t == 1));
            checkOutput("ps_input_en", ps_input_en, (k > 0 && t == 2));
            checkOutput("up_ready", up_ready, exp_ready);
            checkOutput("ps_out_en", ps_out_en, (t == d + 1));
            checkOutput("ps_in", ps_in, pend ? pend_data : '0);
            checkOutput("ps_row", ps_row, m_row);
            checkOutput("ps_col", ps_col, m_col);

            if (ps_out_en && pe_cyc < 0) pe_cyc = t;
            if (done && t_done < 0) t_done = t;
            bufferSample();

            exp_dn = ps_out_valid && (t >= d) && (t < d + DRAIN_CYC) && (rows < M);
            checkOutput("dn_row_valid", dn_row_valid, exp_dn);
            if (t >= d && t < d + DRAIN_CYC)
                checkOutput("dn_row_idx", dn_row_idx, rows % (1 << DW_POS));
            if (exp_dn) rows++;

            pend = 1'b0;
            if (v && exp_ready) begin
                b = sent % BPP;
                r = (b / N) * TILE_M;
                c = b % N;
                for (int l = 0; l < TILE_M; l++)
                    exp_acc[r + l][c] += int'(data[l*DW_DATA +: DW_DATA]);
                pend = 1'b1; pend_data = data; pend_row = r; pend_col = c;
                sent++;
                if (sent == total) d = t + 1;
            end

            if (rst_at > 0 && sent == rst_at) break;
            if (t == d + DRAIN_CYC) break;
            if (t > limit) begin
                checkOutput("job_timeout", t, limit);
                break;
            end
        end

        if (rst_at > 0 && sent == rst_at) begin
            @(negedge clk);
            rst = 1'b1; start = 1'b0; up_valid = 1'b0; ps_out_valid = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkAllZero("mid_rst");
            m_row = 0; m_col = 0; armed = 1'b0; ps_out_valid = 1'b0;
        end else begin
            checkOutput("drain_rows", rows, M);
            // Back-to-back CLEAR, ARM, one beat per cycle, then the drain window
            if (vmode == 0 && k > 0)
                checkOutput("done_latency", t_done - 1, ARM_CYC + 1 + total + DRAIN_CYC);
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    checkOutput($sformatf("acc_r%0d_c%0d", i, j), buf_acc[i][j], exp_acc[i][j]);
        end

        start = 1'b0; up_valid = 1'b0; ps_out_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", done, 0);
            checkOutput("idle_up_ready", up_ready, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                buf_acc[i][j] = 0;
        rst = 1'b1;
        ps_out_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        ps_out_valid = 1'b0;

        $display("[TB] k=1, valid held, ones");
        applyStimulus(1, 0, 0, 16, 0, 1'b0);
        $display("[TB] k=2, valid toggling, ones");
        applyStimulus(2, 1, 0, 16, 0, 1'b0);
        $display("[TB] k=0");
        applyStimulus(0, 0, 0, 16, 0, 1'b0);
        $display("[TB] start poked in ACCUM and DONE");
        applyStimulus(1, 2, 1, 16, 0, 1'b1);
        $display("[TB] reset after 20 transfers");
        applyStimulus(1, 0, 1, 16, 20, 1'b0);
        $display("[TB] clean job after reset");
        applyStimulus(1, 0, 1, 16, 0, 1'b0);
        $display("[TB] buffer emits 18 drain rows");
        applyStimulus(1, 2, 1, 18, 0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            $display("[TB] random job %0d", j);
            applyStimulus($urandom_range(3, 1), 2, 1, 16 + $urandom_range(2, 0), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
